// File: rtl/hack_control.sv
// Multi-cycle Hack CPU control unit: owns PC/A/D/IR, sequences fetch, M read,
// execute and M write through req/ack handshakes, and drives the external ALU.
module hack_control (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] o_instr_addr,
    output logic        o_instr_req,
    input  logic [15:0] i_instr_data,
    input  logic        i_instr_valid,
    output logic [15:0] o_alu_x,
    output logic [15:0] o_alu_y,
    output logic        o_c1,
    output logic        o_c2,
    output logic        o_c3,
    output logic        o_c4,
    output logic        o_c5,
    output logic        o_c6,
    input  logic [15:0] i_alu_out,
    input  logic        i_zo,
    input  logic        i_ng,
    output logic [14:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_re,
    output logic        o_mem_we,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_retire,
    output logic [14:0] o_pc,
    output logic [15:0] o_a,
    output logic [15:0] o_d
);

    // state   | meaning
    // FETCH   | instruction request outstanding
    // DECODE  | A-instr commits here; C-instr picks MREAD or EXEC
    // MREAD   | reading M at A
    // EXEC    | ALU result committed, jump resolved
    // MWRITE  | writing the latched result to the latched address
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MREAD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MWRITE = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [14:0] r_pc, w_pc_nxt, w_pc_inc;
    logic [15:0] r_a, w_a_nxt;
    logic [15:0] r_d, w_d_nxt;
    logic [15:0] r_ir, w_ir_nxt;
    logic [15:0] r_m, w_m_nxt;
    logic [14:0] r_wa, w_wa_nxt;
    logic [15:0] r_wd, w_wd_nxt;
    logic        w_instr_req, w_mem_re, w_mem_we, w_retire, w_jump;
    logic [14:0] w_mem_addr;

    assign w_pc_inc = r_pc + 15'd1;
    assign w_jump   = (r_ir[2] & i_ng) | (r_ir[1] & i_zo) | (r_ir[0] & ~i_ng & ~i_zo);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
        w_ir_nxt    = r_ir;
        w_m_nxt     = r_m;
        w_wa_nxt    = r_wa;
        w_wd_nxt    = r_wd;
        w_instr_req = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_retire    = 1'b0;
        w_mem_addr  = r_a[14:0];
        case (r_state)
            S_FETCH: begin
                w_instr_req = 1'b1;
                if (i_instr_valid) begin
                    w_ir_nxt    = i_instr_data;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!r_ir[15]) begin
                    w_a_nxt     = {1'b0, r_ir[14:0]};
                    w_pc_nxt    = w_pc_inc;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = r_ir[12] ? S_MREAD : S_EXEC;
                end
            end
            S_MREAD: begin
                w_mem_re = 1'b1;
                if (i_mem_ack) begin
                    w_m_nxt     = i_mem_rdata;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // Jump target and write address come from A before this edge.
                w_pc_nxt = w_jump ? r_a[14:0] : w_pc_inc;
                if (r_ir[5]) w_a_nxt = i_alu_out;
                if (r_ir[4]) w_d_nxt = i_alu_out;
                if (r_ir[3]) begin
                    w_wa_nxt    = r_a[14:0];
                    w_wd_nxt    = i_alu_out;
                    w_state_nxt = S_MWRITE;
                end else begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_MWRITE: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_wa;
                if (i_mem_ack) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_ir    <= '0;
            r_m     <= '0;
            r_wa    <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_a     <= w_a_nxt;
            r_d     <= w_d_nxt;
            r_ir    <= w_ir_nxt;
            r_m     <= w_m_nxt;
            r_wa    <= w_wa_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Requests and retire are masked by reset so they drop without a clock edge.
    assign o_instr_req  = w_instr_req & rst_n;
    assign o_mem_re     = w_mem_re & rst_n;
    assign o_mem_we     = w_mem_we & rst_n;
    assign o_retire     = w_retire & rst_n;
    assign o_instr_addr = r_pc;
    assign o_mem_addr   = w_mem_addr;
    assign o_mem_wdata  = r_wd;
    assign o_alu_x      = r_d;
    assign o_alu_y      = r_ir[12] ? r_m : r_a;
    assign o_c1         = r_ir[11];
    assign o_c2         = r_ir[10];
    assign o_c3         = r_ir[9];
    assign o_c4         = r_ir[8];
    assign o_c5         = r_ir[7];
    assign o_c6         = r_ir[6];
    assign o_pc         = r_pc;
    assign o_a          = r_a;
    assign o_d          = r_d;

endmodule

// File: tb/tb_hack_control.sv
// Directed bench for hack_control: Hack ALU model, zero/delayed-wait memory
// responder driven per instruction, hand-computed expectations.
module tb_hack_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] o_instr_addr;
    logic        o_instr_req;
    logic [15:0] i_instr_data;
    logic        i_instr_valid;
    logic [15:0] o_alu_x, o_alu_y;
    logic        o_c1, o_c2, o_c3, o_c4, o_c5, o_c6;
    logic [15:0] i_alu_out;
    logic        i_zo, i_ng;
    logic [14:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_mem_re, o_mem_we;
    logic [15:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_retire;
    logic [14:0] o_pc;
    logic [15:0] o_a, o_d;

    int          n_cmp = 0;
    int          n_err = 0;
    int          t_cycles, t_nre, t_nwe, t_both;
    logic [14:0] t_faddr, t_waddr;
    logic [15:0] t_wdata;
    logic [15:0] m_x, m_y, m_r;

    always #5 clk = ~clk;

    hack_control dut (
        .clk(clk), .rst_n(rst_n),
        .o_instr_addr(o_instr_addr), .o_instr_req(o_instr_req),
        .i_instr_data(i_instr_data), .i_instr_valid(i_instr_valid),
        .o_alu_x(o_alu_x), .o_alu_y(o_alu_y),
        .o_c1(o_c1), .o_c2(o_c2), .o_c3(o_c3), .o_c4(o_c4), .o_c5(o_c5), .o_c6(o_c6),
        .i_alu_out(i_alu_out), .i_zo(i_zo), .i_ng(i_ng),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_retire(o_retire), .o_pc(o_pc), .o_a(o_a), .o_d(o_d)
    );

    // Reference Hack ALU
    always_comb begin
        m_x = o_c1 ? 16'h0000 : o_alu_x;
        if (o_c2) m_x = ~m_x;
        m_y = o_c3 ? 16'h0000 : o_alu_y;
        if (o_c4) m_y = ~m_y;
        m_r = o_c5 ? (m_x + m_y) : (m_x & m_y);
        if (o_c6) m_r = ~m_r;
        i_alu_out = m_r;
        i_zo      = (m_r == 16'h0000);
        i_ng      = m_r[15];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction to its retire; instr_valid is held high throughout,
    // so the DUT must ignore it outside FETCH. Memory ack arrives after mwait
    // wait cycles. Ends just after the edge that commits the instruction.
    task automatic run_instr(input logic [15:0] ins, input int mwait, input logic [15:0] rdata);
        int  wcnt;
        bit  done;
        wcnt      = mwait;
        done      = 1'b0;
        t_cycles  = 0;
        t_nre     = 0;
        t_nwe     = 0;
        t_both    = 0;
        t_waddr   = '0;
        t_wdata   = '0;
        i_instr_data = ins;
        while (!done && t_cycles < 40) begin
            @(negedge clk);
            i_instr_valid = 1'b1;
            i_mem_rdata   = rdata;
            if (o_mem_re || o_mem_we) begin
                if (wcnt == 0) begin
                    i_mem_ack = 1'b1;
                    wcnt      = mwait;
                end else begin
                    i_mem_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                i_mem_ack = 1'b0;
            end
            #1;
            if (t_cycles == 0) t_faddr = o_instr_addr;
            if (o_mem_re) t_nre++;
            if (o_mem_we) begin
                t_nwe++;
                t_waddr = o_mem_addr;
                t_wdata = o_mem_wdata;
            end
            if (o_mem_re && o_mem_we) t_both++;
            done = o_retire;
            t_cycles++;
        end
        if (!done) chk("retire_timeout", 32'(t_cycles), 32'd0);
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0;
        i_mem_ack     = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        i_instr_data  = '0;
        i_instr_valid = 1'b0;
        i_mem_rdata   = '0;
        i_mem_ack     = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_low", 32'(o_instr_req), 32'd0);
        chk("rst_pc", 32'(o_pc), 32'd0);
        chk("rst_a", 32'(o_a), 32'd0);
        chk("rst_d", 32'(o_d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req", 32'(o_instr_req), 32'd1);
        chk("first_addr", 32'(o_instr_addr), 32'd0);
        chk("first_no_mem", 32'({o_mem_re, o_mem_we}), 32'd0);

        // @21 ; D=A
        run_instr(16'h0015, 0, 16'h0);
        chk("ainstr_cycles", 32'(t_cycles), 32'd2);
        chk("ainstr_faddr", 32'(t_faddr), 32'd0);
        run_instr(16'hEC10, 0, 16'h0);
        chk("dA_cycles", 32'(t_cycles), 32'd3);
        chk("dA_faddr", 32'(t_faddr), 32'd1);
        chk("prog1_a", 32'(o_a), 32'h15);
        chk("prog1_d", 32'(o_d), 32'h15);
        chk("prog1_pc", 32'(o_pc), 32'd2);

        // A=7, D=A, A=100, M=D+1
        run_instr(16'h0007, 0, 16'h0);
        run_instr(16'hEC10, 0, 16'h0);
        run_instr(16'h0064, 0, 16'h0);
        chk("pc_before_mw", 32'(o_pc), 32'd5);
        run_instr(16'hE7C8, 0, 16'h0);
        chk("mw_cycles", 32'(t_cycles), 32'd4);
        chk("mw_nwe", 32'(t_nwe), 32'd1);
        chk("mw_nre", 32'(t_nre), 32'd0);
        chk("mw_addr", 32'(t_waddr), 32'd100);
        chk("mw_wdata", 32'(t_wdata), 32'd8);
        chk("mw_d", 32'(o_d), 32'd7);
        chk("mw_pc", 32'(o_pc), 32'd6);

        // A=50, D=M with 3 wait cycles
        run_instr(16'h0032, 0, 16'h0);
        run_instr(16'hFC10, 3, 16'h1234);
        chk("mr_d", 32'(o_d), 32'h1234);
        chk("mr_nre", 32'(t_nre), 32'd4);
        chk("mr_cycles", 32'(t_cycles), 32'd7);
        chk("mr_nwe", 32'(t_nwe), 32'd0);
        chk("mr_pc", 32'(o_pc), 32'd8);

        // D=0, A=8, D;JEQ -> taken
        run_instr(16'h0000, 0, 16'h0);
        run_instr(16'hEC10, 0, 16'h0);
        run_instr(16'h0008, 0, 16'h0);
        run_instr(16'hE302, 0, 16'h0);
        chk("jeq_pc", 32'(o_pc), 32'd8);
        chk("jeq_a", 32'(o_a), 32'd8);

        // D=5, A=8, D;JGT -> taken
        run_instr(16'h0005, 0, 16'h0);
        run_instr(16'hEC10, 0, 16'h0);
        run_instr(16'h0008, 0, 16'h0);
        run_instr(16'hE301, 0, 16'h0);
        chk("jgt_pc", 32'(o_pc), 32'd8);

        // D=5, A=8, D;JLT -> not taken
        run_instr(16'h0005, 0, 16'h0);
        run_instr(16'hEC10, 0, 16'h0);
        run_instr(16'h0008, 0, 16'h0);
        run_instr(16'hE304, 0, 16'h0);
        chk("jlt_pc", 32'(o_pc), 32'd12);
        chk("jlt_d", 32'(o_d), 32'd5);

        // @0x7FFF ; 0;JMP ; then an A-instruction wraps PC to 0
        run_instr(16'h7FFF, 0, 16'h0);
        run_instr(16'hEA87, 0, 16'h0);
        chk("jmp_pc", 32'(o_pc), 32'h7FFF);
        run_instr(16'h0001, 0, 16'h0);
        chk("wrap_faddr", 32'(t_faddr), 32'h7FFF);
        chk("wrap_pc", 32'(o_pc), 32'd0);
        chk("wrap_a", 32'(o_a), 32'd1);
        chk("never_both", 32'(t_both), 32'd0);

        // Reset asserted mid-MWRITE
        run_instr(16'h0064, 0, 16'h0);
        i_instr_data  = 16'hE7C8;
        i_instr_valid = 1'b1;
        i_mem_ack     = 1'b0;
        guard = 0;
        @(negedge clk);
        #1;
        while (!o_mem_we && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("mwrite_reached", 32'(o_mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we_drop", 32'(o_mem_we), 32'd0);
        chk("arst_retire", 32'(o_retire), 32'd0);
        chk("arst_pc", 32'(o_pc), 32'd0);
        chk("arst_a", 32'(o_a), 32'd0);
        chk("arst_d", 32'(o_d), 32'd0);
        i_instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req", 32'(o_instr_req), 32'd1);
        chk("rel_addr", 32'(o_instr_addr), 32'd0);
        run_instr(16'h0003, 0, 16'h0);
        chk("rel_pc", 32'(o_pc), 32'd1);
        chk("rel_a", 32'(o_a), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hack_control.md
# hack_control

Multi-cycle control unit for the Hack CPU. It fetches instructions, decodes them, drives the ALU control bits c1..c6, and consumes the ALU's zo/ng flags to resolve jumps. It owns the A register, D register and program counter, and sequences instruction and data memory through request/acknowledge handshakes. The ALU stays purely combinational and is driven entirely by this block.

## Interface
Parameters:
- none; widths are fixed at 16-bit data and 15-bit addresses.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_addr  out  15  fetch address; equals PC
- instr_req  out  1  fetch request
- instr_data  in  16  instruction word; sampled when instr_req & instr_valid
- instr_valid  in  1  fetch acknowledge
- alu_x  out  16  ALU x operand; always the D register
- alu_y  out  16  ALU y operand; M latch if IR[12]=1, else the A register
- c1..c6  out  1 each  ALU controls; c1=IR[11] … c6=IR[6], driven continuously
- alu_out  in  16  ALU result
- zo, ng  in  1 each  ALU zero and negative flags
- mem_addr  out  15  data address
- mem_wdata  out  16  write data
- mem_re, mem_we  out  1 each  read and write requests; never both high
- mem_rdata  in  16  read data; sampled when mem_re & mem_ack
- mem_ack  in  1  data acknowledge
- retire  out  1  one-cycle pulse when an instruction's last state completes
- pc_o  out  15  debug copy of PC
- a_o, d_o  out  16 each  debug copies of the A and D registers

## Operation
- IR is the instruction register. Instruction decode:
  - IR[15]=0: A-instruction.
  - IR[15]=1: C-instruction, with a=IR[12], comp=IR[11:6], dest d1/d2/d3 = IR[5]/IR[4]/IR[3] (A/D/M), jump j1/j2/j3 = IR[2:0].
  - IR[14:13] are ignored.
- FSM states and transitions:
  - FETCH: instr_req=1. Latch IR and go to DECODE on instr_valid.
  - DECODE:
    - A-instruction: A←{0,IR[14:0]}, PC←PC+1, pulse retire, go to FETCH.
    - C-instruction: go to MREAD if a=1, else EXEC.
  - MREAD: mem_re=1, mem_addr=A[14:0]. On mem_ack, latch M←mem_rdata and go to EXEC.
  - EXEC: sample alu_out, zo, ng.
    - jump = (j1&ng) | (j2&zo) | (j3&~ng&~zo).
    - PC ← jump ? A_old[14:0] : PC+1. A_old is A before this edge; the jump target and M address always use A_old.
    - If d1: A←alu_out. If d2: D←alu_out.
    - If d3: latch wa←A_old[14:0] and wd←alu_out, go to MWRITE.
    - Otherwise pulse retire and go to FETCH.
  - MWRITE: mem_we=1, mem_addr=wa, mem_wdata=wd. On mem_ack, pulse retire and go to FETCH.
- Boundary behaviour:
  - PC is 15 bits and wraps from 0x7FFF+1 to 0x0000.
  - Jumps use the flags of the current result, so a JMP (j=111) is always taken.
  - instr_valid and mem_ack are ignored when the corresponding request is low.
- Reset: PC=0, A=0, D=0, IR=0, M=0, state=FETCH. All request outputs and retire go low immediately on rst_n falling. Any in-flight transaction is abandoned with no commit. After release, the first fetch is at address 0.

## Timing
- Request outputs are decoded from the current state and rise in the first cycle of their state.
- An acknowledge may arrive in that same cycle (zero wait). The request stays high until the cycle in which the acknowledge is sampled.
- Instruction latency with zero-wait memories:
  - A-instruction: 2 cycles.
  - C-instruction: 3 cycles, plus 1 cycle for an M read, plus 1 cycle for an M write.
  - Each wait cycle on a handshake adds one cycle.
- retire is high exactly in the final cycle of an instruction. Architectural state is visible on a_o, d_o and pc_o on the following cycle.
- alu_y switches source combinationally with IR[12]. The ALU has the whole EXEC cycle to settle.

## Test plan
- Reset: hold rst_n low, release → pc_o=0, a_o=0, d_o=0; first instr_req has instr_addr=0; no mem_re or mem_we.
- Program 0x0015 (@21), then 0xEC10 (D=A), zero-wait → a_o=0x0015, d_o=0x0015, pc_o=2; exactly 2 retire pulses in 5 cycles.
- A=100, D=7, then 0xE7C8 (M=D+1) → exactly one mem_we cycle with mem_addr=100, mem_wdata=8; D unchanged; pc_o increments by 1.
- A=50, then 0xFC10 (D=M), mem_ack delayed 3 cycles, mem_rdata=0x1234 → d_o=0x1234; mem_re held for 4 cycles; instruction takes 7 cycles.
- Jumps with A=8:
  - D=0, 0xE302 (D;JEQ) → pc_o=8.
  - D=5, 0xE301 (D;JGT) → pc_o=8.
  - D=5, 0xE304 (D;JLT) → pc_o=PC+1.
  - PC=0x7FFF with a non-jump instruction → pc_o=0.
- Assert rst_n low during MWRITE → mem_we drops in the same cycle without a clock edge; PC/A/D read 0; after release, fetch restarts at 0.
